sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 32, number of entries; a power of two, at least 4.
REQ-003 The block SHALL provide parameter ADDR, default 5, equal to log2(DEPTH).
REQ-004 The block SHALL provide parameter AF_THRESH, default 28, almost-full level; 1..DEPTH-1.
REQ-005 The block SHALL provide parameter AE_THRESH, default 4, almost-empty level; 0..DEPTH-2.
REQ-006 The block SHALL provide parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
 clk  input  1  sole clock, rising edge
 reset_b  input  1  asynchronous reset, active low
 write  input  1  write request
 wdata  input  WIDTH  write data
 read  input  1  read request (pop)
 clr_err  input  1  clears sticky error flags
 rdata  output  WIDTH  read data
 full  output  1  count == DEPTH
 empty  output  1  count == 0
 almost_full  output  1  count >= AF_THRESH
 almost_empty  output  1  count <= AE_THRESH
 count  output  ADDR+1  current occupancy, 0..DEPTH
 overflow  output  1  sticky: write attempted while full
 underflow  output  1  sticky: read attempted while empty

Function
REQ-008 Write and read pointers SHALL be ADDR+1 bits wide; the low ADDR bits address storage, and the MSB toggles on each wrap.
REQ-009 A write SHALL be accepted on a rising clk edge iff write=1 and full=0; the entry is stored at wptr[ADDR-1:0] and wptr increments by 1 modulo 2^(ADDR+1).
REQ-010 A read SHALL be accepted on a rising clk edge iff read=1 and empty=0; rptr increments by 1 modulo 2^(ADDR+1).
REQ-011 Simultaneous accepted read and write SHALL leave count unchanged and move both pointers.
REQ-012 When full and write=1 with read=1 in the same cycle, only the read SHALL be accepted; the write is dropped and overflow sets (no pass-through).
REQ-013 When empty and read=1 with write=1 in the same cycle, only the write SHALL be accepted; underflow sets.
REQ-014 count SHALL be a register equal to wptr-rptr (ADDR+1 bits) and updated on the same edge as the pointers; full, empty, almost_full and almost_empty SHALL be decoded from the registered count.
REQ-015 When FWFT=0, rdata SHALL be a register loaded with the head entry on the edge that accepts a read (one-cycle latency) and SHALL hold its value otherwise.
REQ-016 When FWFT=1, rdata SHALL present the head entry whenever empty=0, with no read required; a read pops the entry and the next entry appears in the following cycle.
REQ-017 When FWFT=1 and empty=1, rdata SHALL equal the value of the last entry popped, or 0 after reset.
REQ-018 overflow SHALL set on any edge with write=1 and full=1, and underflow SHALL set on any edge with read=1 and empty=1; each then holds until clr_err=1.
REQ-019 If a set condition and clr_err=1 occur on the same edge, the set SHALL take priority.
REQ-020 Rejected requests SHALL NOT modify pointers, count or storage.
REQ-021 Storage SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-022 Asserting reset_b=0 SHALL immediately set both pointers and count to 0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0 and rdata=0, independent of clk.
REQ-023 A reset asserted mid-operation SHALL discard all contents; the first accepted write after deassertion lands at address 0.
REQ-024 Release of reset_b SHALL be synchronous to clk in the system; the block performs no accepts on the release edge if write=0 and read=0.

Verification (DEPTH=32, WIDTH=8, AF_THRESH=28, AE_THRESH=4)
REQ-025 Fill: 32 writes of 0x00..0x1F from reset -> count=32, full=1, almost_full from the 28th write, almost_empty=0 after the 5th write; a 33rd write -> overflow=1 and count stays 32.
REQ-026 Drain, FWFT=0: from full, 32 reads -> rdata shows 0x00..0x1F, each one cycle after its read; empty=1 after the last; an extra read -> underflow=1 and rdata holds 0x1F.
REQ-027 Wrap: run 40 cycles of write+read with count held at 3 -> data order is preserved across the pointer wrap, count stays 3 and almost_empty stays 1.
REQ-028 Simultaneous events: when full, write+read -> count=31 and overflow=1; when empty, write+read with wdata=0xA5 -> count=1, underflow=1, and for FWFT=1 rdata=0xA5 on the next cycle.
REQ-029 FWFT=1: write 0x11 then 0x22 -> rdata=0x11 with no read; one read -> rdata=0x22 the next cycle.
REQ-030 Reset mid-stream: reset_b=0 at count=17 with overflow=1 -> all outputs take their REQ-022 values immediately; clr_err together with a new underflow event -> underflow stays 1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy flags, sticky error flags, and a choice of
// registered-read or first-word-fall-through output.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int ADDR      = 5,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR:0] ONE      = (ADDR+1)'(1);
  localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AF_CNT   = (ADDR+1)'(AF_THRESH);
  localparam logic [ADDR:0] AE_CNT   = (ADDR+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR:0]    wptr_q, wptr_d;
  logic [ADDR:0]    rptr_q, rptr_d;
  logic [ADDR:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] head;

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = write & ~full;
  assign rd_acc = read & ~empty;
  assign head   = mem_q[rptr_q[ADDR-1:0]];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    if (wr_acc) wptr_d = wptr_q + ONE;
    if (rd_acc) begin
      rptr_d  = rptr_q + ONE;
      rdata_d = head;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    // A new error event wins over a simultaneous clear.
    ovf_d = (write & full)  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d = (read  & empty) ? 1'b1 : (clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ADDR-1:0]] <= wdata;
  end

  // rdata_q holds the last popped word; in FWFT mode it is only visible when empty.
  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = empty ? rdata_q : head;
    end else begin : g_reg
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read and one FWFT instance
// share stimulus and are compared every cycle against a queue-based model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       write, read, clr_err;
  logic [7:0] wdata;

  logic [7:0] rdata0, rdata1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [5:0] count0, count1;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  logic [7:0] mq[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rd0, m_last;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(32), .ADDR(5), .AF_THRESH(28), .AE_THRESH(4), .FWFT(0)) u_reg (
    .clk(clk), .reset_b(reset_b), .write(write), .wdata(wdata), .read(read), .clr_err(clr_err),
    .rdata(rdata0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.WIDTH(8), .DEPTH(32), .ADDR(5), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset_b(reset_b), .write(write), .wdata(wdata), .read(read), .clr_err(clr_err),
    .rdata(rdata1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_rd0  = 8'h00;
    m_last = 8'h00;
  endtask

  task automatic model_update(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit mfull, mempty;
    logic [7:0] v;
    mfull  = (mq.size() == 32);
    mempty = (mq.size() == 0);
    if (r && !mempty) begin
      v      = mq.pop_front();
      m_rd0  = v;
      m_last = v;
    end
    if (w && !mfull) mq.push_back(d);
    if (w && mfull) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && mempty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    write   = w;
    wdata   = d;
    read    = r;
    clr_err = c;
    @(posedge clk);
    model_update(w, d, r, c);
    #1;
    write   = 1'b0;
    read    = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_count0", 32'(count0), 32'd0);
    check("rst_count1", 32'(count1), 32'd0);
    check("rst_flags0", 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'b010100);
    check("rst_flags1", 32'({full1, empty1, af1, ae1, ovf1, unf1}), 32'b010100);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
  endtask

  // Asserted mid-cycle, away from any clock edge, so the check proves asynchrony.
  task automatic apply_reset();
    reset_b = 1'b0;
    model_reset();
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset_b = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      logic [5:0] ef;
      n  = mq.size();
      ef = {n == 32, n == 0, n >= 28, n <= 4, m_ovf, m_unf};
      check("cnt0",   32'(count0), 32'(n));
      check("cnt1",   32'(count1), 32'(n));
      check("flags0", 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'(ef));
      check("flags1", 32'({full1, empty1, af1, ae1, ovf1, unf1}), 32'(ef));
      check("rdata0", 32'(rdata0), 32'(m_rd0));
      check("rdata1", 32'(rdata1), (n > 0) ? 32'(mq[0]) : 32'(m_last));
    end
  end

  initial begin
    reset_b = 1'b0;
    write = 1'b0; read = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    model_reset();
    #2;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    chk_en  = 1'b1;

    // Fill from empty and overflow once.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 3)  check("ae_at4",  32'(ae0), 32'd1);
      if (i == 4)  check("ae_at5",  32'(ae0), 32'd0);
      if (i == 26) check("af_at27", 32'(af0), 32'd0);
      if (i == 27) check("af_at28", 32'(af0), 32'd1);
    end
    check("fill_full", 32'({full0, count0}), 32'({1'b1, 6'd32}));
    check("fwft_head", 32'(rdata1), 32'h00);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovf_33rd", 32'({ovf0, count0}), 32'({1'b1, 6'd32}));

    // Drain with one-cycle read latency, then underflow.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_rd0", 32'(rdata0), 32'(i));
    end
    check("drain_empty", 32'(empty0), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_extra", 32'({unf0, rdata0}), 32'({1'b1, 8'h1F}));
    check("fwft_last", 32'(rdata1), 32'h1F);

    // Empty with write+read: only the write lands.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_clr", 32'(unf0), 32'd0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("empty_wr_rd", 32'({unf0, count0}), 32'({1'b1, 6'd1}));
    check("empty_wr_rd_fwft", 32'(rdata1), 32'hA5);

    // Full with write+read: only the read lands.
    for (int i = 0; i < 31; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b1);
    check("refill_full", 32'(full0), 32'd1);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_wr_rd", 32'({ovf0, count0}), 32'({1'b1, 6'd31}));
    check("full_wr_rd_rd0", 32'(rdata0), 32'hA5);

    // Steady state at depth 3 across the pointer wrap.
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 8'h30 + 8'(k), 1'b1, 1'b0);
      check("wrap_rd0", 32'(rdata0), (k < 3) ? 32'(8'hC0 + 8'(k)) : 32'(8'h30 + 8'(k - 3)));
      check("wrap_cnt_ae", 32'({count0, ae0}), 32'({6'd3, 1'b1}));
    end

    // FWFT head presentation.
    apply_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    check("fwft_11", 32'(rdata1), 32'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_22", 32'(rdata1), 32'h22);

    // Reset mid-stream at count 17 with overflow set.
    apply_reset();
    for (int i = 0; i < 33; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst", 32'({ovf0, count0}), 32'({1'b1, 6'd17}));
    apply_reset();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("clr_vs_unf", 32'(unf0), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("post_rst_wr", 32'({count1, rdata1}), 32'({6'd1, 8'h77}));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_rd0", 32'(rdata0), 32'h77);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
